// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Chunk counter width; kept at least one bit so NCH=1 still has a legal vector.
  function automatic int unsigned cnt_width(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Operand width must split evenly into whole chunks.
  function automatic bit chunk_cfg_ok(input int unsigned width, input int unsigned chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational ripple-carry adder for one CHUNK-bit slice.
module chunk_ripple_adder #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = c_i;

  for (genvar i = 0; i < CHUNK; i++) begin : g_cell
    assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign c_o     = carry[CHUNK];
  // Carry into the top bit; XOR with c_o gives signed overflow.
  assign c_msb_o = carry[CHUNK - 1];

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per clock with a registered carry.
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCH = WIDTH / CHUNK;
  localparam int unsigned CW  = cnt_width(NCH);
  localparam logic [CW-1:0] LastCnt = CW'(NCH - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("seq_addsub: WIDTH must be a positive multiple of CHUNK");
  end

  state_e state_q, state_d;

  // sub is folded into b_q (inverted) and the initial carry, so it needs no register.
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_slice, b_slice, sum_slice;
  logic             slice_cout, slice_cmsb;
  logic             accept;

  assign accept  = start && ((state_q == StIdle) || (state_q == StDone));
  assign a_slice = a_q[cnt_q * CHUNK +: CHUNK];
  assign b_slice = b_q[cnt_q * CHUNK +: CHUNK];

  chunk_ripple_adder #(
    .CHUNK(CHUNK)
  ) u_adder (
    .a_i     (a_slice),
    .b_i     (b_slice),
    .c_i     (carry_q),
    .s_o     (sum_slice),
    .c_o     (slice_cout),
    .c_msb_o (slice_cmsb)
  );

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase

    if (accept) begin
      a_d     = A;
      b_d     = sub ? ~B : B;
      carry_d = sub;
      cnt_d   = '0;
    end else if (state_q == StRun) begin
      s_d[cnt_q * CHUNK +: CHUNK] = sum_slice;
      carry_d = slice_cout;
      if (cnt_q == LastCnt) begin
        cnt_d  = '0;
        cout_d = slice_cout;
        ovf_d  = slice_cmsb ^ slice_cout;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, result, counter and carry registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign S    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
